// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode slice of the 16-bit pipelined CPU.
package decode_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_B    = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LDR  = 4'h9;
    localparam logic [3:0] OP_STR  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_AND  = 4'hE;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;

    localparam logic [1:0] RI_RD2  = 2'b00;
    localparam logic [1:0] RI_RD3  = 2'b01;
    localparam logic [1:0] RI_SEXT = 2'b10;
    localparam logic [1:0] RI_ZEXT = 2'b11;

    typedef struct packed {
        logic       wbs;
        logic       wme;
        logic       mm;
        logic [2:0] ALUop;
        logic       wm;
        logic       am;
        logic       ni;
    } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control bundle, srcB select and register write enable.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic       flagN_i,
    input  logic       flagZ_i,
    output ctrl_t      ctrl_o,
    output logic [1:0] ri_o,
    output logic       wre_o
);

    always_comb begin
        ctrl_o = '0;
        ri_o   = RI_RD2;
        wre_o  = 1'b0;
        case (opcode_i)
            OP_ADD:  begin ctrl_o.ALUop = ALU_ADD; wre_o = 1'b1; end
            OP_SUB:  begin ctrl_o.ALUop = ALU_SUB; wre_o = 1'b1; end
            OP_ADDI: begin ctrl_o.ALUop = ALU_ADD; ri_o = RI_SEXT; wre_o = 1'b1; end
            OP_BEQ:  begin ri_o = RI_ZEXT; ctrl_o.ni = flagZ_i; end
            OP_BLT:  begin ri_o = RI_ZEXT; ctrl_o.ni = flagN_i; end
            OP_B:    begin ri_o = RI_ZEXT; ctrl_o.ni = 1'b1; end
            OP_CMP:  begin ctrl_o.ALUop = ALU_SUB; end
            OP_MOV:  begin ri_o = RI_SEXT; ctrl_o.mm = 1'b1; wre_o = 1'b1; end
            OP_LDR: begin
                ctrl_o.ALUop = ALU_ADD;
                ri_o         = RI_SEXT;
                ctrl_o.am    = 1'b1;
                ctrl_o.wbs   = 1'b1;
                wre_o        = 1'b1;
            end
            OP_STR: begin
                ctrl_o.ALUop = ALU_ADD;
                ri_o         = RI_SEXT;
                ctrl_o.am    = 1'b1;
                ctrl_o.wme   = 1'b1;
                ctrl_o.wm    = 1'b1;
            end
            OP_MUL:  begin ctrl_o.ALUop = ALU_MUL; wre_o = 1'b1; end
            OP_SHL:  begin ctrl_o.ALUop = ALU_SHL; wre_o = 1'b1; end
            OP_SHR:  begin ctrl_o.ALUop = ALU_SHR; wre_o = 1'b1; end
            OP_AND:  begin ctrl_o.ALUop = ALU_AND; wre_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, control decode, operand selection and ID/EX register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instruction_fetch,
    input  logic              fd_en,
    input  logic              flush,
    input  logic              flagN,
    input  logic              flagZ,
    output logic [REG_AW-1:0] a1,
    output logic [REG_AW-1:0] a2,
    output logic [REG_AW-1:0] a3,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] rd3,
    output logic              wre,
    output logic              ni,
    output logic [DATA_W-1:0] instruction_decode,
    output logic              wbs_ex,
    output logic              wme_ex,
    output logic              mm_ex,
    output logic              wm_ex,
    output logic              am_ex,
    output logic              ni_ex,
    output logic [2:0]        ALUop_ex,
    output logic [DATA_W-1:0] srcA_ex,
    output logic [DATA_W-1:0] srcB_ex
);

    logic [DATA_W-1:0] instr_q, instr_d;
    ctrl_t             ctrl;
    logic [1:0]        ri;
    logic [DATA_W-1:0] sext, zext, srcB;
    ctrl_t             exCtrl_q, exCtrl_d;
    logic [DATA_W-1:0] srcAEx_q, srcAEx_d, srcBEx_q, srcBEx_d;

    decode_ctrl u_ctrl (
        .opcode_i (instr_q[15:12]),
        .flagN_i  (flagN),
        .flagZ_i  (flagZ),
        .ctrl_o   (ctrl),
        .ri_o     (ri),
        .wre_o    (wre)
    );

    assign sext = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};
    assign zext = {{(DATA_W-12){1'b0}}, instr_q[11:0]};

    always_comb begin
        srcB = rd2;
        case (ri)
            RI_RD2:  srcB = rd2;
            RI_RD3:  srcB = rd3;
            RI_SEXT: srcB = sext;
            RI_ZEXT: srcB = zext;
            default: srcB = rd2;
        endcase
    end

    // Flush beats the load enable; a stalled IF/ID lets ID/EX re-capture the same decode.
    always_comb begin
        instr_d  = instr_q;
        exCtrl_d = ctrl;
        srcAEx_d = rd1;
        srcBEx_d = srcB;
        if (flush) begin
            instr_d  = '0;
            exCtrl_d = '0;
            srcAEx_d = '0;
            srcBEx_d = '0;
        end else if (fd_en) begin
            instr_d = instruction_fetch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            exCtrl_q <= '0;
            srcAEx_q <= '0;
            srcBEx_q <= '0;
        end else begin
            instr_q  <= instr_d;
            exCtrl_q <= exCtrl_d;
            srcAEx_q <= srcAEx_d;
            srcBEx_q <= srcBEx_d;
        end
    end

    assign a1                 = instr_q[REG_AW-1:0];
    assign a2                 = instr_q[2*REG_AW-1:REG_AW];
    assign a3                 = instr_q[3*REG_AW-1:2*REG_AW];
    assign ni                 = ctrl.ni;
    assign instruction_decode = instr_q;
    assign wbs_ex             = exCtrl_q.wbs;
    assign wme_ex             = exCtrl_q.wme;
    assign mm_ex              = exCtrl_q.mm;
    assign wm_ex              = exCtrl_q.wm;
    assign am_ex              = exCtrl_q.am;
    assign ni_ex              = exCtrl_q.ni;
    assign ALUop_ex           = exCtrl_q.ALUop;
    assign srcA_ex            = srcAEx_q;
    assign srcB_ex            = srcBEx_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instruction_fetch;
    logic        fd_en, flush, flagN, flagZ;
    logic [3:0]  a1, a2, a3;
    logic [15:0] rd1, rd2, rd3;
    logic        wre, ni;
    logic [15:0] instruction_decode;
    logic        wbs_ex, wme_ex, mm_ex, wm_ex, am_ex, ni_ex;
    logic [2:0]  ALUop_ex;
    logic [15:0] srcA_ex, srcB_ex;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        wbs, wme, mm, wm, am, ni, wre;
        logic [2:0]  aluOp;
        logic [15:0] srcA, srcB;
    } exp_t;

    logic [15:0] mIfid;
    exp_t        mEx;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction_fetch  (instruction_fetch),
        .fd_en              (fd_en),
        .flush              (flush),
        .flagN              (flagN),
        .flagZ              (flagZ),
        .a1                 (a1),
        .a2                 (a2),
        .a3                 (a3),
        .rd1                (rd1),
        .rd2                (rd2),
        .rd3                (rd3),
        .wre                (wre),
        .ni                 (ni),
        .instruction_decode (instruction_decode),
        .wbs_ex             (wbs_ex),
        .wme_ex             (wme_ex),
        .mm_ex              (mm_ex),
        .wm_ex              (wm_ex),
        .am_ex              (am_ex),
        .ni_ex              (ni_ex),
        .ALUop_ex           (ALUop_ex),
        .srcA_ex            (srcA_ex),
        .srcB_ex            (srcB_ex)
    );

    // What each instruction means: which ALU op, which second operand, writes and branch decision.
    function automatic exp_t refModel(input logic [15:0] ins, input logic fN, input logic fZ,
                                      input logic [15:0] r1, input logic [15:0] r2);
        exp_t        e;
        logic [15:0] sImm, zImm;
        sImm   = ins[7] ? (16'(ins[7:0]) - 16'd256) : 16'(ins[7:0]);
        zImm   = ins % 16'h1000;
        e      = '0;
        e.srcA = r1;
        e.srcB = r2;
        case (ins[15:12])
            4'd1:  begin e.aluOp = 3'd0; e.wre = 1'b1; end
            4'd2:  begin e.aluOp = 3'd1; e.wre = 1'b1; end
            4'd3:  begin e.aluOp = 3'd0; e.srcB = sImm; e.wre = 1'b1; end
            4'd4:  begin e.srcB = zImm; e.ni = fZ; end
            4'd5:  begin e.srcB = zImm; e.ni = fN; end
            4'd6:  begin e.srcB = zImm; e.ni = 1'b1; end
            4'd7:  begin e.aluOp = 3'd1; end
            4'd8:  begin e.srcB = sImm; e.mm = 1'b1; e.wre = 1'b1; end
            4'd9:  begin e.srcB = sImm; e.am = 1'b1; e.wbs = 1'b1; e.wre = 1'b1; end
            4'd10: begin e.srcB = sImm; e.am = 1'b1; e.wme = 1'b1; e.wm = 1'b1; end
            4'd11: begin e.aluOp = 3'd2; e.wre = 1'b1; end
            4'd12: begin e.aluOp = 3'd3; e.wre = 1'b1; end
            4'd13: begin e.aluOp = 3'd4; e.wre = 1'b1; end
            4'd14: begin e.aluOp = 3'd5; e.wre = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkAll();
        exp_t cur;
        cur = refModel(mIfid, flagN, flagZ, rd1, rd2);
        checkOutput("instruction_decode", instruction_decode, mIfid);
        checkOutput("a1", 16'(a1), mIfid % 16);
        checkOutput("a2", 16'(a2), (mIfid / 16) % 16);
        checkOutput("a3", 16'(a3), (mIfid / 256) % 16);
        checkOutput("wre", 16'(wre), 16'(cur.wre));
        checkOutput("ni", 16'(ni), 16'(cur.ni));
        checkOutput("wbs_ex", 16'(wbs_ex), 16'(mEx.wbs));
        checkOutput("wme_ex", 16'(wme_ex), 16'(mEx.wme));
        checkOutput("mm_ex", 16'(mm_ex), 16'(mEx.mm));
        checkOutput("wm_ex", 16'(wm_ex), 16'(mEx.wm));
        checkOutput("am_ex", 16'(am_ex), 16'(mEx.am));
        checkOutput("ni_ex", 16'(ni_ex), 16'(mEx.ni));
        checkOutput("ALUop_ex", 16'(ALUop_ex), 16'(mEx.aluOp));
        checkOutput("srcA_ex", srcA_ex, mEx.srcA);
        checkOutput("srcB_ex", srcB_ex, mEx.srcB);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_instr"}, instruction_decode, 16'h0000);
        checkOutput({tag, "_ctrl"},
                    16'({wbs_ex, wme_ex, mm_ex, wm_ex, am_ex, ni_ex, ALUop_ex}), 16'h0000);
        checkOutput({tag, "_srcA"}, srcA_ex, 16'h0000);
        checkOutput({tag, "_srcB"}, srcB_ex, 16'h0000);
    endtask

    // Called just after a falling edge; drives inputs, advances one rising edge, checks, returns at the next falling edge.
    task automatic applyStimulus(input logic [15:0] ins, input logic fd, input logic fl,
                                 input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3,
                                 input logic fN, input logic fZ);
        instruction_fetch = ins;
        fd_en = fd;
        flush = fl;
        rd1 = r1;
        rd2 = r2;
        rd3 = r3;
        flagN = fN;
        flagZ = fZ;
        @(posedge clk);
        if (fl) begin
            mEx   = '0;
            mIfid = 16'h0000;
        end else begin
            mEx = refModel(mIfid, fN, fZ, r1, r2);
            if (fd) mIfid = ins;
        end
        #1;
        checkAll();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        instruction_fetch = '0;
        fd_en = 1'b0;
        flush = 1'b0;
        flagN = 1'b0;
        flagZ = 1'b0;
        rd1 = '0;
        rd2 = '0;
        rd3 = '0;
        mIfid = '0;
        mEx = '0;
        #12;
        checkCleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h1012, 1, 0, 16'h0005, 16'h0003, 16'h0000, 0, 0);
        checkOutput("add_if_id", instruction_decode, 16'h1012);
        checkOutput("add_a1", 16'(a1), 16'd2);
        checkOutput("add_wre", 16'(wre), 16'd1);
        applyStimulus(16'h4008, 1, 0, 16'h0005, 16'h0003, 16'h0000, 0, 1);
        checkOutput("add_srcA", srcA_ex, 16'h0005);
        checkOutput("add_srcB", srcB_ex, 16'h0003);
        checkOutput("beq_ni_taken", 16'(ni), 16'd1);
        checkOutput("beq_wre", 16'(wre), 16'd0);
        applyStimulus(16'h4008, 1, 0, 16'h0001, 16'h0002, 16'h0000, 0, 0);
        checkOutput("beq_ni_ex", 16'(ni_ex), 16'd0);
        checkOutput("beq_srcB", srcB_ex, 16'h0008);
        checkOutput("beq_ni_not_taken", 16'(ni), 16'd0);
        applyStimulus(16'h8232, 1, 0, 16'h0001, 16'h0002, 16'h0000, 0, 1);
        checkOutput("beq_ni_ex_taken", 16'(ni_ex), 16'd1);
        applyStimulus(16'h82F6, 1, 0, 16'h0001, 16'h0002, 16'h0000, 0, 0);
        checkOutput("mov_mm_ex", 16'(mm_ex), 16'd1);
        checkOutput("mov_srcB", srcB_ex, 16'h0032);
        applyStimulus(16'hA104, 1, 0, 16'h0001, 16'h0002, 16'h0000, 0, 0);
        checkOutput("mov_sext_srcB", srcB_ex, 16'hFFF6);
        checkOutput("str_wre", 16'(wre), 16'd0);
        applyStimulus(16'h1234, 0, 0, 16'h0010, 16'h0002, 16'h0000, 0, 0);
        checkOutput("str_wme_wm_am", 16'({wme_ex, wm_ex, am_ex}), 16'd7);
        checkOutput("str_srcA", srcA_ex, 16'h0010);
        checkOutput("str_srcB", srcB_ex, 16'h0004);
        applyStimulus(16'h5678, 0, 0, 16'h0010, 16'h0002, 16'h0000, 0, 0);
        checkOutput("stall_hold", instruction_decode, 16'hA104);
        applyStimulus(16'h1012, 1, 1, 16'h0010, 16'h0002, 16'h0000, 0, 0);
        checkCleared("flush");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkCleared("async_reset");
                mIfid = '0;
                mEx = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            applyStimulus(16'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                          16'($urandom), 16'($urandom), 16'($urandom),
                          1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
